// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core load/store
// port (fixed priority) and an external requester (DMA, loader, debug).
// External accesses take one grant cycle and are acknowledged with a one-cycle
// ext_ack pulse in the following cycle.
// Optional feature macro: DMEM_ARB_STARVE_EN enables anti-starvation, which
// forces an external grant over the core after MAX_WAIT lost arbitrations and
// stalls the core for that one cycle.
module dmem_arbiter #(
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [3:0]  core_be,
  output logic [31:0] core_rdata,
  output logic        core_stall,
  input  logic        ext_req,
  input  logic        ext_we,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wdata,
  input  logic [3:0]  ext_be,
  output logic        ext_ack,
  output logic [31:0] ext_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata
);

  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("dmem_arbiter: MAX_WAIT must be >= 1");
  end

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  state_t state;
  state_t state_next;
  logic   grant_ext;
  logic   forced;

`ifdef DMEM_ARB_STARVE_EN
  localparam int                WW      = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0]     MAX_CNT = WW'(MAX_WAIT);

  logic [WW-1:0] wait_cnt;

  // Count arbitration losses of a pending external request, saturating at MAX_WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (state == IDLE) begin
      if (grant_ext || !ext_req) begin
        wait_cnt <= '0;
      end else if (core_req && (wait_cnt != MAX_CNT)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  assign forced     = (wait_cnt == MAX_CNT);
  assign core_stall = grant_ext && core_req;
`else
  assign forced     = 1'b0;
  assign core_stall = 1'b0;
`endif

  assign grant_ext  = (state == IDLE) && ext_req && (!core_req || forced);
  assign core_rdata = mem_rdata;
  assign ext_ack    = (state == ACK);

  // State register: a grant is always followed by exactly one ACK cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: ext_req is ignored while in ACK so a held request is re-arbitrated afterwards.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_ext) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture external read data at the end of the grant cycle; writes leave it unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ext_rdata <= 32'h0000_0000;
    end else if (grant_ext && !ext_we) begin
      ext_rdata <= mem_rdata;
    end
  end

  // Memory mux: the granted external port or the core; writes are blocked while in reset.
  always_comb begin
    mem_we    = core_we && core_req;
    mem_addr  = core_addr;
    mem_wdata = core_wdata;
    mem_be    = core_be;
    if (grant_ext) begin
      mem_we    = ext_we;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
      mem_be    = ext_be;
    end
    if (!reset) begin
      mem_we = 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of dmem_arbiter against a small behavioural dmem.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        core_req, core_we;
  logic [31:0] core_addr, core_wdata;
  logic [3:0]  core_be;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        ext_req, ext_we;
  logic [31:0] ext_addr, ext_wdata;
  logic [3:0]  ext_be;
  logic        ext_ack;
  logic [31:0] ext_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;

  int totalChecks = 0;
  int badChecks   = 0;

  logic [31:0] dmem [0:255];

  dmem_arbiter #(.MAX_WAIT(8)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_be(core_be),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_be(ext_be),
    .ext_ack(ext_ack), .ext_rdata(ext_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural dmem: asynchronous read, byte-enabled write at the rising edge.
  assign mem_rdata = dmem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) dmem[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic creq, input logic cwe, input logic [31:0] caddr,
                               input logic [31:0] cwdata, input logic [3:0] cbe,
                               input logic ereq, input logic ewe, input logic [31:0] eaddr,
                               input logic [31:0] ewdata, input logic [3:0] ebe);
    core_req   = creq;
    core_we    = cwe;
    core_addr  = caddr;
    core_wdata = cwdata;
    core_be    = cbe;
    ext_req    = ereq;
    ext_we     = ewe;
    ext_addr   = eaddr;
    ext_wdata  = ewdata;
    ext_be     = ebe;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  int ackSeen;
  int coreBad;

  initial begin
    for (int i = 0; i < 256; i++) dmem[i] = 32'h0;
    dmem[8'h10] = 32'h1111_1111;
    dmem[8'h20] = 32'h1234_5678;

    // Reset with the core attempting a store.
    reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 32'h40, 32'hAAAA_AAAA, 4'hF, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    nextCycle();
    nextCycle();
    @(negedge clk);
    checkOutput("rst_mem_we", 32'(mem_we), 32'h0);
    checkOutput("rst_ext_ack", 32'(ext_ack), 32'h0);
    checkOutput("rst_ext_rdata", ext_rdata, 32'h0);
    checkOutput("rst_core_stall", 32'(core_stall), 32'h0);
    checkOutput("rst_mem_addr", mem_addr, 32'h40);
    nextCycle();
    checkOutput("rst_no_write", dmem[8'h10], 32'h1111_1111);
    reset = 1'b1;

    // External write with the core idle.
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk);
    checkOutput("wr_mem_we", 32'(mem_we), 32'h1);
    checkOutput("wr_mem_addr", mem_addr, 32'h40);
    checkOutput("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    checkOutput("wr_mem_be", 32'(mem_be), 32'hF);
    checkOutput("wr_ack_early", 32'(ext_ack), 32'h0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("wr_ack", 32'(ext_ack), 32'h1);
    checkOutput("wr_core_load", core_rdata, 32'hDEAD_BEEF);
    checkOutput("wr_rdata_kept", ext_rdata, 32'h0);
    nextCycle();
    @(negedge clk);
    checkOutput("wr_ack_pulse", 32'(ext_ack), 32'h0);

    // External read held high across ACK: ACK, re-grant, ACK.
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h80, 32'h0, 4'hF);
    @(negedge clk);
    checkOutput("rd_mem_we", 32'(mem_we), 32'h0);
    nextCycle();
    @(negedge clk);
    checkOutput("rd_ack1", 32'(ext_ack), 32'h1);
    checkOutput("rd_data", ext_rdata, 32'h1234_5678);
    nextCycle();
    @(negedge clk);
    checkOutput("rd_regrant_gap", 32'(ext_ack), 32'h0);
    nextCycle();
    @(negedge clk);
    checkOutput("rd_ack2", 32'(ext_ack), 32'h1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    nextCycle();
    @(negedge clk);
    checkOutput("rd_data_persist", ext_rdata, 32'h1234_5678);
    checkOutput("rd_ack_idle", 32'(ext_ack), 32'h0);

`ifdef DMEM_ARB_STARVE_EN
    // Anti-starvation: forced grant in cycle 8, ACK in cycle 9.
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h80, 32'h0, 4'hF, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checkOutput($sformatf("starve_stall_c%0d", i), 32'(core_stall), (i == 8) ? 32'h1 : 32'h0);
      checkOutput($sformatf("starve_ack_c%0d", i), 32'(ext_ack), (i == 9) ? 32'h1 : 32'h0);
      if (i == 8) checkOutput("starve_mem_addr", mem_addr, 32'h40);
      if (i == 9) begin
        checkOutput("starve_rdata", ext_rdata, 32'hDEAD_BEEF);
        checkOutput("starve_core_in_ack", core_rdata, 32'h1234_5678);
      end
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    nextCycle();
`else
    // Core priority: a busy core starves the external port indefinitely.
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h80, 32'h0, 4'hF, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
    ackSeen = 0;
    coreBad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ext_ack) ackSeen++;
      if (core_rdata !== 32'h1234_5678 || mem_addr !== 32'h80 || core_stall !== 1'b0) coreBad++;
      nextCycle();
    end
    checkOutput("prio_no_ack", 32'(ackSeen), 32'h0);
    checkOutput("prio_core_ok", 32'(coreBad), 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
    @(negedge clk);
    checkOutput("prio_grant_addr", mem_addr, 32'h40);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("prio_ack", 32'(ext_ack), 32'h1);
    checkOutput("prio_rdata", ext_rdata, 32'hDEAD_BEEF);
    nextCycle();
`endif

    // Reset asserted during an external write grant cycle.
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h40, 32'hCAFE_F00D, 4'hF);
    @(negedge clk);
    checkOutput("rstg_grant_we", 32'(mem_we), 32'h1);
    reset = 1'b0;
    #1;
    checkOutput("rstg_we_blocked", 32'(mem_we), 32'h0);
    nextCycle();
    checkOutput("rstg_no_ack", 32'(ext_ack), 32'h0);
    checkOutput("rstg_mem_kept", dmem[8'h10], 32'hDEAD_BEEF);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rstg_reissue_we", 32'(mem_we), 32'h1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("rstg_reissue_ack", 32'(ext_ack), 32'h1);
    checkOutput("rstg_core_load", core_rdata, 32'hCAFE_F00D);
    nextCycle();

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
